pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control block for the fetch-stage program counter register. Each cycle it decides whether the PC advances (`pcen`) and what it loads (`next_pc`): sequential, branch, jump or jump-register target. Redirects that arrive while fetch is stalled are held in a one-entry pending register and applied when the stall clears. The block also generates front-end flushes and the core-halt state. One instance per core sits between the hazard unit, the decode/execute redirect sources and the PC register.

## Interface
- `PC_W`, 32, PC width in bits.
- `CLK  input  1  clock, rising edge`
- `RST  input  1  reset, synchronous, active-high`
- `pc  input  PC_W  current PC register value`
- `npc  input  PC_W  pc + 4 from PC register`
- `ihit  input  1  instruction fetch completed this cycle`
- `freeze  input  1  hazard-unit stall of the front end`
- `br_taken  input  1  EX-stage branch resolved taken`
- `br_target  input  PC_W  branch target`
- `jmp  input  1  ID-stage J/JAL`
- `jmp_target  input  PC_W  jump target`
- `jr  input  1  ID-stage JR`
- `jr_target  input  PC_W  register target`
- `halt  input  1  halt instruction retiring in WB`
- `pcen  output  1  PC register load enable`
- `next_pc  output  PC_W  value loaded into PC when pcen=1`
- `flush_if  output  1  kill IF/ID contents`
- `flush_id  output  1  kill ID/EX contents (branch redirects only)`
- `halted  output  1  core halted`

## Operation
- States: RUN, PEND, HALT. Pending register: `pend_tgt[PC_W-1:0]`, `pend_br` (1 = branch, 0 = jump).
- `stall = freeze | ~ihit`.
- Redirect priority within a cycle: `br_taken` > `jr` > `jmp`. The branch is older, so jr/jmp in the same cycle are wrong-path and are dropped.
- **RUN**, no stall:
  - `pcen=1`.
  - `next_pc` is the highest-priority redirect target, else `npc`.
  - `flush_if=1` on any redirect. `flush_id=1` on a branch.
- **RUN**, stall with a redirect: `pcen=0`. Capture target and type into pend, then go to PEND. No flush yet.
- **RUN**, stall without a redirect: `pcen=0`, stay in RUN.
- **PEND**:
  - A new `br_taken` overwrites pend (`pend_br=1`).
  - A new jmp/jr is ignored, because pend already redirects the stream.
  - When `stall=0`: `pcen=1`, `next_pc=pend_tgt` (or `br_target` if `br_taken` this cycle). Flushes follow the applied type. Return to RUN.
- **HALT**: entered from any state when `halt=1`. Halt beats every other input in that cycle: `pcen=0`, no flush. While in HALT: `pcen=0`, `halted=1`, all inputs ignored. Only RST exits.
- `next_pc` is don't-care when `pcen=0` but is driven as `npc` for determinism.

## Timing
- All outputs are combinational from state, pend and inputs. State and pend update on the rising CLK edge.
- Redirect with no stall: the PC holds the target after 1 edge, i.e. zero added bubbles beyond the flush.
- Redirect during stall: applied in the first cycle with `stall=0`. The PC holds the target one edge later.
- Reset (synchronous, RST=1 at an edge): state=RUN, pend cleared. Outputs with RST held high: `pcen=0`, `flush_if=0`, `flush_id=0`, `halted=0`, `next_pc=npc`. RST overrides halt and pending redirects in the same cycle.
- Simultaneous stall deassert and new branch in PEND: the new branch wins.
- `halt` and `br_taken` in the same cycle: halt wins and the branch is discarded.
- Target arithmetic: none; targets pass through unmodified (PC_W bits, no wrap handling).

## Structure
- The shared package holds:
  - `pcseq_state_t` enum (RUN, PEND, HALT).
  - `redir_t` enum (NONE, BR, JR, JMP).
  - `PC_W` default, tied to the existing word type.
- Natural sub-module: `redirect_pri`, a combinational priority select producing `redir_t` and the target. Reuse it for both the RUN path and the PEND override.
- Connects to the program counter interface's `pcen`/`next_pc` side.

## Test plan
- Reset: RST=1 for 2 cycles with `br_taken=1`, `halt=1` → `pcen=0`, `halted=0`, no flush. After release with `ihit=1`, pc=0x0, npc=0x4 → `pcen=1`, `next_pc=0x4`.
- Branch, no stall: `br_taken=1`, `br_target=0x100` and `jmp=1`, `jmp_target=0x200` in the same cycle → `next_pc=0x100`, `flush_if=1`, `flush_id=1`.
- Jump during a 3-cycle ihit miss: `jmp=1`, `jmp_target=0x40` on cycle 0 only → `pcen=0` for 3 cycles. On the first `ihit=1`: `pcen=1`, `next_pc=0x40`, `flush_if=1`, `flush_id=0`.
- Override in PEND: pending jmp to 0x40, then `br_taken=1` to 0x80 while frozen → on unfreeze, `next_pc=0x80`, `flush_id=1`.
- Halt: `halt=1` together with `br_taken=1` → `pcen=0` and `halted=1` from the next cycle on, through 10 cycles of random redirects; RST then clears to RUN.
- Freeze only: `freeze=1`, `ihit=1`, no redirects for 4 cycles → `pcen=0` throughout, state RUN, resuming `next_pc=npc`.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types for the fetch PC sequencer
package pc_sequencer_pkg;

  // Machine word; the PC is one word wide by default
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  localparam int PC_W_DEFAULT = $bits(word_t);

  // Sequencer states: normal run, redirect held across a stall, core halted
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } pcseq_state_t;

  // Winning redirect source for the current cycle
  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    JR   = 2'd2,
    JMP  = 2'd3
  } redir_t;

  function automatic logic is_redirect(input redir_t r);
    return r != NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_redirect_pri.sv
// rtl/pc_sequencer_redirect_pri.sv - priority select among branch, jr and jump redirects
module pc_sequencer_redirect_pri
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  output redir_t          redir,
  output logic [PC_W-1:0] target
);

  // The EX branch is the oldest instruction, so it beats both ID redirects
  always_comb begin
    redir  = NONE;
    target = '0;
    if (br_taken) begin
      redir  = BR;
      target = br_target;
    end else if (jr) begin
      redir  = JR;
      target = jr_target;
    end else if (jmp) begin
      redir  = JMP;
      target = jmp_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC advance/redirect control with pending redirect and halt
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] npc,
  input  logic            ihit,
  input  logic            freeze,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  input  logic            halt,
  output logic            pcen,
  output logic [PC_W-1:0] next_pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            halted
);

  pcseq_state_t    state_q, state_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_br_q, pend_br_d;

  redir_t          redir;
  logic [PC_W-1:0] redir_tgt;
  logic            stall;

  // The current PC is not needed: sequential fetch uses npc directly
  logic unused_pc;
  assign unused_pc = ^pc;

  assign stall = freeze | ~ihit;

  pc_sequencer_redirect_pri #(
    .PC_W(PC_W)
  ) u_pri (
    .br_taken  (br_taken),
    .br_target (br_target),
    .jr        (jr),
    .jr_target (jr_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .redir     (redir),
    .target    (redir_tgt)
  );

  // Next-state and output decode; reset and halt dominate every redirect
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    pend_br_d  = pend_br_q;
    pcen       = 1'b0;
    next_pc    = npc;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    halted     = 1'b0;

    if (RST) begin
      state_d    = RUN;
      pend_tgt_d = '0;
      pend_br_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            state_d = HALT;
          end else if (!stall) begin
            pcen = 1'b1;
            if (is_redirect(redir)) begin
              next_pc  = redir_tgt;
              flush_if = 1'b1;
              flush_id = (redir == BR);
            end
          end else if (is_redirect(redir)) begin
            // Hold the redirect until fetch can accept it; flush then
            pend_tgt_d = redir_tgt;
            pend_br_d  = (redir == BR);
            state_d    = PEND;
          end
        end

        PEND: begin
          if (halt) begin
            state_d = HALT;
          end else if (!stall) begin
            pcen     = 1'b1;
            flush_if = 1'b1;
            state_d  = RUN;
            // A branch arriving on the release cycle is older than the pend
            if (redir == BR) begin
              next_pc  = redir_tgt;
              flush_id = 1'b1;
            end else begin
              next_pc  = pend_tgt_q;
              flush_id = pend_br_q;
            end
          end else if (redir == BR) begin
            // Only a branch can displace a pending redirect; jr/jmp behind
            // it are already on the wrong path
            pend_tgt_d = redir_tgt;
            pend_br_d  = 1'b1;
          end
        end

        HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and pending-redirect registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      pend_tgt_q <= '0;
      pend_br_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      pend_br_q  <= pend_br_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table, halt sequence and random model check for pc_sequencer
module tb_pc_sequencer;

  typedef struct {
    bit          rst;
    bit          ihit;
    bit          frz;
    bit          br;
    logic [31:0] brt;
    bit          jr;
    logic [31:0] jrt;
    bit          jm;
    logic [31:0] jmt;
    bit          hlt;
    logic [31:0] np;
    bit          e_pcen;
    logic [31:0] e_next;
    bit          e_fif;
    bit          e_fid;
    bit          e_hlt;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc, npc, br_target, jmp_target, jr_target;
  logic        ihit, freeze, br_taken, jmp, jr, halt;
  logic        pcen, flush_if, flush_id, halted;
  logic [31:0] next_pc;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_halted;
  bit          m_pending;
  logic [31:0] m_pend_tgt;
  bit          m_pend_br;

  vec_t vt[$];

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .pc        (pc),
    .npc       (npc),
    .ihit      (ihit),
    .freeze    (freeze),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .jr        (jr),
    .jr_target (jr_target),
    .halt      (halt),
    .pcen      (pcen),
    .next_pc   (next_pc),
    .flush_if  (flush_if),
    .flush_id  (flush_id),
    .halted    (halted)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input bit rst, input bit ih, input bit frz,
                             input bit br, input logic [31:0] brt,
                             input bit jrr, input logic [31:0] jrt,
                             input bit jm, input logic [31:0] jmt,
                             input bit hlt, input logic [31:0] np,
                             input bit e_pcen, input logic [31:0] e_next,
                             input bit e_fif, input bit e_fid, input bit e_hlt);
    vec_t r;
    r.rst = rst; r.ihit = ih; r.frz = frz; r.br = br; r.brt = brt;
    r.jr = jrr; r.jrt = jrt; r.jm = jm; r.jmt = jmt; r.hlt = hlt; r.np = np;
    r.e_pcen = e_pcen; r.e_next = e_next; r.e_fif = e_fif; r.e_fid = e_fid;
    r.e_hlt = e_hlt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", name, act, exp_v, $time);
  endtask

  task automatic drive(input vec_t x);
    RST = x.rst; ihit = x.ihit; freeze = x.frz;
    br_taken = x.br; br_target = x.brt;
    jr = x.jr; jr_target = x.jrt;
    jmp = x.jm; jmp_target = x.jmt;
    halt = x.hlt; npc = x.np; pc = x.np - 32'd4;
  endtask

  task automatic check_all(input string tag, input vec_t x);
    chk({tag, ".pcen"},     {31'd0, pcen},     {31'd0, x.e_pcen});
    chk({tag, ".next_pc"},  next_pc,           x.e_next);
    chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, x.e_fif});
    chk({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, x.e_fid});
    chk({tag, ".halted"},   {31'd0, halted},   {31'd0, x.e_hlt});
  endtask

  // Expected outputs from the rules: reset, then halt, then release/redirect
  function automatic vec_t model_expect(input vec_t x);
    vec_t e = x;
    bit stall_c;
    logic [31:0] want;
    bit any;
    stall_c = x.frz || !x.ihit;
    any = x.br || x.jr || x.jm;
    want = x.br ? x.brt : (x.jr ? x.jrt : x.jmt);
    e.e_pcen = 0; e.e_next = x.np; e.e_fif = 0; e.e_fid = 0; e.e_hlt = 0;
    if (x.rst) return e;
    if (m_halted) begin e.e_hlt = 1; return e; end
    if (x.hlt) return e;
    if (!stall_c) begin
      e.e_pcen = 1;
      if (m_pending) begin
        e.e_fif = 1;
        e.e_next = x.br ? x.brt : m_pend_tgt;
        e.e_fid = x.br ? 1'b1 : m_pend_br;
      end else if (any) begin
        e.e_fif = 1;
        e.e_next = want;
        e.e_fid = x.br;
      end
    end
    return e;
  endfunction

  task automatic model_update(input vec_t x);
    bit stall_c;
    stall_c = x.frz || !x.ihit;
    if (x.rst) begin
      m_halted = 0; m_pending = 0; m_pend_tgt = '0; m_pend_br = 0;
    end else if (m_halted) begin
    end else if (x.hlt) begin
      m_halted = 1;
    end else if (!stall_c) begin
      m_pending = 0;
    end else if (m_pending) begin
      if (x.br) begin m_pend_tgt = x.brt; m_pend_br = 1; end
    end else if (x.br || x.jr || x.jm) begin
      m_pending = 1;
      m_pend_br = x.br;
      m_pend_tgt = x.br ? x.brt : (x.jr ? x.jrt : x.jmt);
    end
  endtask

  function automatic vec_t rand_vec(input bit allow_rst);
    vec_t r;
    r.rst  = allow_rst && ($urandom_range(0, 49) == 0);
    r.ihit = ($urandom_range(0, 3) != 0);
    r.frz  = ($urandom_range(0, 3) == 0);
    r.br   = ($urandom_range(0, 4) == 0);
    r.jr   = ($urandom_range(0, 6) == 0);
    r.jm   = ($urandom_range(0, 6) == 0);
    r.hlt  = ($urandom_range(0, 59) == 0);
    r.brt  = $urandom & 32'hFFFF_FFFC;
    r.jrt  = $urandom & 32'hFFFF_FFFC;
    r.jmt  = $urandom & 32'hFFFF_FFFC;
    r.np   = $urandom & 32'hFFFF_FFFC;
    r.e_pcen = 0; r.e_next = '0; r.e_fif = 0; r.e_fid = 0; r.e_hlt = 0;
    return r;
  endfunction

  initial begin
    vec_t x;
    drive(v(1,1,0, 1,32'h100, 0,0, 0,0, 1, 32'h4, 0,32'h4,0,0,0));

    // rst ih frz | br brt | jr jrt | jm jmt | hlt npc || pcen next fif fid hlt
    vt.push_back(v(1,1,0, 1,32'h100, 0,0, 0,0, 1,32'h4,   0,32'h4,0,0,0));
    vt.push_back(v(1,1,0, 1,32'h100, 0,0, 0,0, 1,32'h4,   0,32'h4,0,0,0));
    vt.push_back(v(0,1,0, 0,0, 0,0, 0,0, 0,32'h4,         1,32'h4,0,0,0));
    vt.push_back(v(0,1,0, 1,32'h100, 0,0, 1,32'h200, 0,32'h8, 1,32'h100,1,1,0));
    vt.push_back(v(0,0,0, 0,0, 0,0, 1,32'h40, 0,32'h104,  0,32'h104,0,0,0));
    vt.push_back(v(0,0,0, 0,0, 0,0, 0,0, 0,32'h104,       0,32'h104,0,0,0));
    vt.push_back(v(0,0,0, 0,0, 0,0, 0,0, 0,32'h104,       0,32'h104,0,0,0));
    vt.push_back(v(0,1,0, 0,0, 0,0, 0,0, 0,32'h104,       1,32'h40,1,0,0));
    vt.push_back(v(0,1,1, 0,0, 0,0, 1,32'h40, 0,32'h44,   0,32'h44,0,0,0));
    vt.push_back(v(0,1,1, 1,32'h80, 0,0, 0,0, 0,32'h44,   0,32'h44,0,0,0));
    vt.push_back(v(0,1,0, 0,0, 0,0, 0,0, 0,32'h44,        1,32'h80,1,1,0));
    for (int i = 0; i < 4; i++)
      vt.push_back(v(0,1,1, 0,0, 0,0, 0,0, 0,32'h84,      0,32'h84,0,0,0));
    vt.push_back(v(0,1,0, 0,0, 0,0, 0,0, 0,32'h84,        1,32'h84,0,0,0));
    vt.push_back(v(0,1,1, 0,0, 1,32'h300, 0,0, 0,32'h88,  0,32'h88,0,0,0));
    vt.push_back(v(0,1,0, 1,32'h500, 0,0, 1,32'h600, 0,32'h88, 1,32'h500,1,1,0));
    vt.push_back(v(0,1,1, 0,0, 0,0, 1,32'h700, 0,32'h504, 0,32'h504,0,0,0));
    vt.push_back(v(0,1,1, 0,0, 1,32'h900, 1,32'hA00, 0,32'h504, 0,32'h504,0,0,0));
    vt.push_back(v(0,1,0, 0,0, 0,0, 0,0, 0,32'h504,       1,32'h700,1,0,0));
    vt.push_back(v(0,0,0, 0,0, 1,32'h30, 0,0, 0,32'h704,  0,32'h704,0,0,0));
    vt.push_back(v(0,1,0, 0,0, 0,0, 0,0, 0,32'h704,       1,32'h30,1,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      drive(vt[i]);
      #1;
      check_all($sformatf("vec%0d", i), vt[i]);
    end

    // Halt together with a branch: halt wins, then sticky through redirects
    @(negedge CLK);
    x = v(0,1,0, 1,32'h1000, 0,0, 0,0, 1,32'h34, 0,32'h34,0,0,0);
    drive(x); #1; check_all("halt_entry", x);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      x = rand_vec(0);
      x.hlt = $urandom_range(0, 1);
      x.e_pcen = 0; x.e_next = x.np; x.e_fif = 0; x.e_fid = 0; x.e_hlt = 1;
      drive(x); #1; check_all($sformatf("halted%0d", i), x);
    end
    @(negedge CLK);
    x = v(1,1,0, 1,32'h2000, 0,0, 0,0, 0,32'h10, 0,32'h10,0,0,0);
    drive(x); #1; check_all("halt_rst", x);
    @(negedge CLK);
    x = v(0,1,0, 0,0, 0,0, 0,0, 0,32'h14, 1,32'h14,0,0,0);
    drive(x); #1; check_all("halt_release", x);

    // Randomized run against the behavioural model
    m_halted = 0; m_pending = 0; m_pend_tgt = '0; m_pend_br = 0;
    for (int i = 0; i < 600; i++) begin
      vec_t e;
      @(negedge CLK);
      x = rand_vec(1);
      if (i == 0) x.rst = 1;
      e = model_expect(x);
      drive(x); #1;
      check_all($sformatf("rand%0d", i), e);
      model_update(x);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
